pikachu_motion: RTL and testbench
=================================

# pikachu_motion

Sequential position/animation controller sitting directly upstream of the `pikachu` sprite renderer. Samples player buttons once per video frame and runs a ground/jump state machine to produce the sprite's top-left position (`pos_x`, `pos_y`). Toggles the walk-frame select `par` at a fixed frame rate while walking. Also drives the per-pixel `enable` window that tells the renderer when the scan position is inside the 32×16 sprite.

## Interface
Parameters:
- `X_START`, 64: reset `pos_x`
- `X_MIN`, 0: leftmost legal `pos_x`
- `X_MAX`, 607: rightmost legal `pos_x` (640 − 32 − 1)
- `GROUND_Y`, 400: resting `pos_y`
- `STEP_X`, 2: horizontal pixels per frame tick
- `JUMP_H`, 64: apex height above `GROUND_Y`; must be a multiple of `STEP_Y`
- `STEP_Y`, 4: vertical pixels per frame tick
- `ANIM_DIV`, 8: frame ticks per `par` toggle

Ports:
- `clk`, in, 1: pixel clock; the only clock
- `rst`, in, 1: asynchronous, active-high reset
- `frame_tick`, in, 1: one-cycle pulse per frame, at start of vertical blank
- `btn_left`, in, 1: asynchronous button, active-high
- `btn_right`, in, 1: asynchronous button, active-high
- `btn_jump`, in, 1: asynchronous button, active-high
- `x`, in, 10: current scan column from the VGA timing block
- `y`, in, 10: current scan row from the VGA timing block
- `pos_x`, out, 10: sprite column origin, registered
- `pos_y`, out, 10: sprite row origin, registered
- `par`, out, 1: walk-frame select, registered
- `enable`, out, 1: scan position is inside the sprite, combinational
- `airborne`, out, 1: high in RISE or FALL, registered

## Operation
- Buttons pass through a 2-flop synchronizer. All state updates happen only in a cycle with `frame_tick`=1 and use the synchronized values from that cycle. Outputs are therefore constant across the visible frame, so there is no tearing.
- Reset (async, from any state, mid-jump included) sets:
  - `pos_x`=`X_START`, `pos_y`=`GROUND_Y`, `par`=0, `airborne`=0
  - state GROUND, animation counter 0, jump-armed flag 1
  - synchronizer flops 0
- Horizontal move, evaluated on every tick in all states:
  - left only: `pos_x` = max(`pos_x` − `STEP_X`, `X_MIN`)
  - right only: `pos_x` = min(`pos_x` + `STEP_X`, `X_MAX`)
  - both or neither: no motion
  - Arithmetic is done in 11 bits so it cannot underflow or overflow before the clamp.
- State machine, transitions on tick only:
  - GROUND: if jump=1 and armed → RISE, armed←0. Jump released sets armed←1, so holding jump never re-triggers.
  - RISE: `pos_y` −= `STEP_Y`. When the new `pos_y` equals `GROUND_Y` − `JUMP_H` → FALL.
  - FALL: `pos_y` += `STEP_Y`. When the new `pos_y` equals `GROUND_Y` → GROUND.
  - Jump presses in RISE or FALL are ignored. The armed flag still tracks release in all states.
- Animation:
  - In GROUND with horizontal motion requested (exactly one direction pressed): counter increments per tick. At `ANIM_DIV`−1 it wraps to 0 and `par` toggles.
  - This holds even when the position is clamped at a wall.
  - In GROUND with no motion: counter←0, `par`←0.
  - In RISE/FALL: counter and `par` hold.
- Enable window: `enable`=1 iff `pos_x`+1 ≤ `x` ≤ `pos_x`+32 and `pos_y` ≤ `y` ≤ `pos_y`+15. Compares are done in 11 bits. This column offset of one matches the renderer's `x − pos_x − 1` indexing.

## Timing
- Register outputs change one `clk` after the `frame_tick` cycle.
- A button needs 2 clk of synchronizer latency before the tick to take effect. Changes inside that window apply on the following frame.
- Jump duration: 2·`JUMP_H`/`STEP_Y` ticks. Defaults give 16 RISE plus 16 FALL = 32 ticks. `airborne` drops on the same edge `pos_y` returns to `GROUND_Y`.
- `enable` has zero latency relative to `x`, `y`.
- `frame_tick` asserted on consecutive cycles is legal. Each cycle counts as a separate tick.

## Structure
- Package `pikachu_pkg` holds:
  - `motion_state_t` enum {GROUND, RISE, FALL}
  - constants `SPR_W`=32, `SPR_H`=16, `SCR_W`=640, `SCR_H`=480
  - The renderer and this block share the package.
- Sub-module `btn_sync`: 3-bit 2-flop synchronizer with async active-high reset to 0.

## Test plan
- Reset asserted mid-FALL at `pos_y`=360 → same cycle `pos_y`=400, `pos_x`=64, `par`=0, `airborne`=0.
- Right held for 10 ticks from 64 → `pos_x`=84. `par` toggles after tick 8 (0→1) and is 1 at tick 10. Release → next tick `par`=0.
- Left held from `pos_x`=3 → 1 after one tick, then 0 and stays 0. Right held from 605 → 607, then stays 607. Both held → no motion, `par`=0.
- Jump pulsed for one tick:
  - `pos_y` reaches 336 after 16 ticks and 400 after 32.
  - `airborne`=1 for exactly 32 ticks.
  - Jump held throughout the flight → no second jump until released and pressed again.
- Right held while airborne for 32 ticks → `pos_x` +64, `par` frozen at its value when the jump started.
- `pos_x`=100, `pos_y`=200:
  - `x`=100 → `enable`=0; `x`=101 → 1; `x`=132 → 1; `x`=133 → 0 (all at `y`=200)
  - `y`=215 → 1; `y`=216 → 0

Source files
------------

// File: rtl/pikachu_pkg.sv
// Shared definitions for the pikachu sprite motion controller and renderer.
package pikachu_pkg;

  // Vertical motion phases of the sprite.
  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } motion_state_t;

  // Sprite and screen geometry shared with the renderer.
  localparam int SPR_W = 32;
  localparam int SPR_H = 16;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;

  // True when v lies in the inclusive range [lo, hi]; 11-bit so sums never wrap.
  function automatic logic in_span(input logic [10:0] v,
                                   input logic [10:0] lo,
                                   input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pikachu_btn_sync.sv
// Two-flop synchronizer for the three asynchronous player buttons.
module btn_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] raw,
  output logic [2:0] synced
);

  logic [2:0] meta;

  // Two register stages give metastability time to settle before use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 3'b000;
      synced <= 3'b000;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/pikachu_motion.sv
// Frame-rate position, jump and walk-animation controller for the pikachu sprite.
// All state advances only on frame_tick so outputs are stable across a visible frame.
module pikachu_motion
  import pikachu_pkg::*;
#(
  parameter int X_START  = 64,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 607,
  parameter int GROUND_Y = 400,
  parameter int STEP_X   = 2,
  parameter int JUMP_H   = 64,
  parameter int STEP_Y   = 4,
  parameter int ANIM_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       par,
  output logic       enable,
  output logic       airborne
);

  localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic [10:0] X_MIN_W    = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W    = 11'(X_MAX);
  localparam logic [10:0] STEP_X_W   = 11'(STEP_X);
  localparam logic [9:0]  STEP_Y_V   = 10'(STEP_Y);
  localparam logic [9:0]  GROUND_V   = 10'(GROUND_Y);
  localparam logic [9:0]  APEX_V     = 10'(GROUND_Y - JUMP_H);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);

  logic [2:0]        btn_s;
  logic              left_s;
  logic              right_s;
  logic              jump_s;
  logic              walk_req;
  logic [10:0]       x_left;
  logic [10:0]       x_right;
  logic [9:0]        next_x;
  logic [9:0]        y_up;
  logic [9:0]        y_down;
  motion_state_t     state;
  logic              armed;
  logic [CNT_W-1:0]  anim_cnt;

  btn_sync u_btn_sync (
    .clk    (clk),
    .rst    (rst),
    .raw    ({btn_jump, btn_right, btn_left}),
    .synced (btn_s)
  );

  assign left_s   = btn_s[0];
  assign right_s  = btn_s[1];
  assign jump_s   = btn_s[2];
  assign walk_req = left_s ^ right_s;

  assign y_up   = pos_y - STEP_Y_V;
  assign y_down = pos_y + STEP_Y_V;

  // Clamped horizontal target; 11-bit math keeps the wall compare free of wrap-around.
  always_comb begin
    x_left  = {1'b0, pos_x} - STEP_X_W;
    x_right = {1'b0, pos_x} + STEP_X_W;
    next_x  = pos_x;
    if (left_s && !right_s) begin
      if ({1'b0, pos_x} < (X_MIN_W + STEP_X_W)) next_x = X_MIN_W[9:0];
      else                                       next_x = x_left[9:0];
    end else if (right_s && !left_s) begin
      if (x_right > X_MAX_W) next_x = X_MAX_W[9:0];
      else                   next_x = x_right[9:0];
    end
  end

  // Ground/jump state machine plus position, animation and airborne registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= GROUND;
      pos_x    <= 10'(X_START);
      pos_y    <= GROUND_V;
      par      <= 1'b0;
      airborne <= 1'b0;
      anim_cnt <= '0;
      armed    <= 1'b1;
    end else if (frame_tick) begin
      pos_x <= next_x;

      if (!jump_s) armed <= 1'b1;

      case (state)
        GROUND: begin
          if (walk_req) begin
            if (anim_cnt == CNT_LAST) begin
              anim_cnt <= '0;
              par      <= ~par;
            end else begin
              anim_cnt <= anim_cnt + 1'b1;
            end
          end else begin
            anim_cnt <= '0;
            par      <= 1'b0;
          end
          if (jump_s && armed) begin
            state    <= RISE;
            armed    <= 1'b0;
            airborne <= 1'b1;
          end
        end
        RISE: begin
          pos_y <= y_up;
          if (y_up == APEX_V) state <= FALL;
        end
        FALL: begin
          pos_y <= y_down;
          if (y_down == GROUND_V) begin
            state    <= GROUND;
            airborne <= 1'b0;
          end
        end
        default: begin
          state    <= GROUND;
          pos_y    <= GROUND_V;
          airborne <= 1'b0;
        end
      endcase
    end
  end

  // Scan-position window; column offset of one matches the renderer's indexing.
  assign enable = in_span({1'b0, x}, {1'b0, pos_x} + 11'd1, {1'b0, pos_x} + 11'(SPR_W)) &&
                  in_span({1'b0, y}, {1'b0, pos_y}, {1'b0, pos_y} + 11'(SPR_H - 1));

endmodule

// File: tb/tb_pikachu_motion.sv
// Self-checking bench for pikachu_motion: reference model plus directed literal checks.
module tb_pikachu_motion;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       btn_left, btn_right, btn_jump;
  logic [9:0] x, y;
  logic [9:0] pos_x, pos_y;
  logic       par, enable, airborne;

  logic [9:0] x2, y2;
  logic [9:0] pos_x2, pos_y2;
  logic       par2, enable2, airborne2;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // model state
  int mx, my, mpar, mcnt, mair, mflight, marmed;

  localparam int RISE_N = 64 / 4;

  pikachu_motion dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .x(x), .y(y), .pos_x(pos_x), .pos_y(pos_y),
    .par(par), .enable(enable), .airborne(airborne)
  );

  pikachu_motion #(.X_START(100), .GROUND_Y(200)) dut_win (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_left(1'b0), .btn_right(1'b0), .btn_jump(1'b0),
    .x(x2), .y(y2), .pos_x(pos_x2), .pos_y(pos_y2),
    .par(par2), .enable(enable2), .airborne(airborne2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void model_reset();
    mx = 64; my = 400; mpar = 0; mcnt = 0; mair = 0; mflight = 0; marmed = 1;
  endfunction

  // One frame of game rules, using the button levels held steady by the stimulus.
  function automatic void model_tick();
    int launch;
    launch = (!mair && btn_jump && marmed) ? 1 : 0;
    if (!btn_jump) marmed = 1;
    else if (launch != 0) marmed = 0;

    if (!mair) begin
      if (btn_left != btn_right) begin
        mcnt = mcnt + 1;
        if (mcnt == 8) begin
          mcnt = 0;
          mpar = 1 - mpar;
        end
      end else begin
        mcnt = 0;
        mpar = 0;
      end
    end

    if (btn_left && !btn_right)      mx = (mx - 2 < 0) ? 0 : mx - 2;
    else if (btn_right && !btn_left) mx = (mx + 2 > 607) ? 607 : mx + 2;

    if (mair != 0) begin
      mflight = mflight + 1;
      my = (mflight <= RISE_N) ? 400 - 4 * mflight : 400 - 4 * (2 * RISE_N - mflight);
      if (mflight == 2 * RISE_N) mair = 0;
    end else if (launch != 0) begin
      mair = 1;
      mflight = 0;
    end
  endfunction

  // Issue n frame ticks, optionally back-to-back, advancing the model after each edge.
  task automatic ticks(input int n, input bit back_to_back);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      model_tick();
      if (!back_to_back) frame_tick = 1'b0;
    end
    #1 frame_tick = 1'b0;
  endtask

  // Set button levels, let them cross the synchronizer, then run n ticks.
  task automatic applyStimulus(input bit l, input bit r, input bit j, input int n,
                               input bit back_to_back = 1'b0);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = j;
    repeat (3) @(posedge clk);
    ticks(n, back_to_back);
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      checkOutput("pos_x", int'(pos_x), mx);
      checkOutput("pos_y", int'(pos_y), my);
      checkOutput("par", int'(par), mpar);
      checkOutput("airborne", int'(airborne), mair);
      checkOutput("enable", int'(enable),
                  (int'(x) >= mx + 1 && int'(x) <= mx + 32 &&
                   int'(y) >= my && int'(y) <= my + 15) ? 1 : 0);
    end
  end

  // Scan position wanders around the sprite so both enable edges get exercised.
  initial begin
    x = 10'd0; y = 10'd0;
    forever begin
      @(posedge clk);
      #2;
      x = 10'(mx + int'($urandom_range(0, 34)));
      y = 10'(my - 1 + int'($urandom_range(0, 17)));
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int air_cnt;
    int x0;
    rst = 1'b1; frame_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    x2 = 10'd0; y2 = 10'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_pos_x", int'(pos_x), 64);
    checkOutput("reset_pos_y", int'(pos_y), 400);
    checkOutput("reset_par", int'(par), 0);
    checkOutput("reset_airborne", int'(airborne), 0);
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Walk right: par toggles on the eighth tick.
    applyStimulus(0, 1, 0, 7);
    checkOutput("walk_par_t7", int'(par), 0);
    ticks(1, 1'b0);
    checkOutput("walk_par_t8", int'(par), 1);
    ticks(2, 1'b0);
    checkOutput("walk_pos_x_t10", int'(pos_x), 84);
    checkOutput("walk_par_t10", int'(par), 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("release_par", int'(par), 0);
    checkOutput("release_pos_x", int'(pos_x), 84);

    // Walls, using back-to-back ticks.
    applyStimulus(0, 1, 0, 270, 1'b1);
    checkOutput("right_wall", int'(pos_x), 607);
    applyStimulus(1, 0, 0, 302, 1'b1);
    checkOutput("left_to_3", int'(pos_x), 3);
    ticks(1, 1'b0);
    checkOutput("left_to_1", int'(pos_x), 1);
    ticks(1, 1'b0);
    checkOutput("left_to_0", int'(pos_x), 0);
    ticks(3, 1'b1);
    checkOutput("left_hold_0", int'(pos_x), 0);
    applyStimulus(0, 1, 0, 310, 1'b1);
    applyStimulus(1, 0, 0, 1);
    checkOutput("at_605", int'(pos_x), 605);
    applyStimulus(0, 1, 0, 1);
    checkOutput("right_to_607", int'(pos_x), 607);
    ticks(2, 1'b0);
    checkOutput("right_hold_607", int'(pos_x), 607);
    applyStimulus(1, 1, 0, 3);
    checkOutput("both_pos_x", int'(pos_x), 607);
    checkOutput("both_par", int'(par), 0);

    // Jump held for the whole flight and beyond.
    air_cnt = 0;
    applyStimulus(0, 0, 1, 1);
    checkOutput("launch_airborne", int'(airborne), 1);
    checkOutput("launch_pos_y", int'(pos_y), 400);
    air_cnt += int'(airborne);
    for (int i = 1; i <= 35; i++) begin
      ticks(1, 1'b0);
      air_cnt += int'(airborne);
      if (i == 16) checkOutput("apex_pos_y", int'(pos_y), 336);
      if (i == 32) checkOutput("land_pos_y", int'(pos_y), 400);
    end
    checkOutput("airborne_ticks", air_cnt, 32);
    checkOutput("held_no_retrigger", int'(airborne), 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("repress_launch", int'(airborne), 1);
    applyStimulus(0, 0, 0, 32);
    checkOutput("repress_landed", int'(airborne), 0);

    // Walk while airborne: position moves, par stays frozen.
    applyStimulus(1, 0, 0, 150);
    checkOutput("left_150", int'(pos_x), 307);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 8);
    checkOutput("pre_jump_par", int'(par), 1);
    applyStimulus(0, 1, 1, 1);
    x0 = int'(pos_x);
    applyStimulus(0, 1, 0, 32);
    checkOutput("air_walk_pos_x", int'(pos_x), x0 + 64);
    checkOutput("air_walk_par", int'(par), 1);
    checkOutput("air_walk_landed", int'(airborne), 0);

    // Reset in the middle of the fall.
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 22);
    checkOutput("mid_fall_pos_y", int'(pos_y), 360);
    @(negedge clk);
    cmp_en = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_pos_y", int'(pos_y), 400);
    checkOutput("async_rst_pos_x", int'(pos_x), 64);
    checkOutput("async_rst_par", int'(par), 0);
    checkOutput("async_rst_airborne", int'(airborne), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    applyStimulus(0, 1, 0, 3);

    // Enable window on the second instance parked at (100, 200).
    checkOutput("win_pos_x", int'(pos_x2), 100);
    checkOutput("win_pos_y", int'(pos_y2), 200);
    y2 = 10'd200;
    x2 = 10'd100; #1 checkOutput("en_x100", int'(enable2), 0);
    x2 = 10'd101; #1 checkOutput("en_x101", int'(enable2), 1);
    x2 = 10'd132; #1 checkOutput("en_x132", int'(enable2), 1);
    x2 = 10'd133; #1 checkOutput("en_x133", int'(enable2), 0);
    x2 = 10'd110;
    y2 = 10'd215; #1 checkOutput("en_y215", int'(enable2), 1);
    y2 = 10'd216; #1 checkOutput("en_y216", int'(enable2), 0);
    y2 = 10'd199; #1 checkOutput("en_y199", int'(enable2), 0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
